param_onehot_decoder_pipe: RTL and testbench

//  Parametrised, registered successor of the 4-in/10-out active-low decoder: SEL_W-bit index -> NUM_OUT one-hot
//  (optionally active-low) output word. Adds valid/ready streaming, a 1-cycle output register, and out-of-range

---
 rtl/param_onehot_decoder_pkg.sv | 27 ++
 rtl/onehot_dec_core.sv | 30 +++
 rtl/param_onehot_decoder_pipe.sv | 192 +++++++++++++++++++
 tb/tb_param_onehot_decoder_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_onehot_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : param_onehot_decoder_pkg
// Brief   : Shared types and polarity helpers for the one-hot decoder pipe.
// Revision: 1.0 - initial release
// ============================================================================
package param_onehot_decoder_pkg;

    // Control state of the decoder pipe.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no beat held on the outputs
        HOLD = 2'd1,   // one beat held, waiting for the consumer
        SCAN = 2'd2    // walking indices, more beats still to come
    } state_t;

    // Fill level of an inactive output bit; replicated to form the idle word.
    function automatic logic inactive_word(input logic active_low);
        return active_low;
    endfunction

    // Maps an active-high decoded bit onto the configured output polarity.
    function automatic logic polarity(input logic bit_hot, input logic active_low);
        return bit_hot ^ active_low;
    endfunction

endpackage : param_onehot_decoder_pkg
`default_nettype wire

// File: rtl/onehot_dec_core.sv
`default_nettype none
// ============================================================================
// Module  : onehot_dec_core
// Brief   : Combinational index -> active-high one-hot decode with range flag.
// Revision: 1.0 - initial release
// ============================================================================
module onehot_dec_core
    import param_onehot_decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int NUM_OUT = 10
) (
    input  logic [SEL_W-1:0]   i_idx,
    output logic [NUM_OUT-1:0] o_onehot,
    output logic               o_range_err
);

    // Both sides widened to 32 bits so NUM_OUT == 2**SEL_W never truncates;
    // in that case the flag is a constant zero.
    assign o_range_err = (32'(i_idx) >= 32'(NUM_OUT));

    // An out-of-range index matches no bit, leaving the word all-zero.
    generate
        for (genvar g = 0; g < NUM_OUT; g++) begin : g_bit
            assign o_onehot[g] = (32'(i_idx) == 32'(g));
        end
    endgenerate

endmodule : onehot_dec_core
`default_nettype wire

// File: rtl/param_onehot_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : param_onehot_decoder_pipe
// Brief   : Registered valid/ready one-hot decoder with SCAN walk mode,
//           out-of-range detection and a sticky error flag.
// Revision: 1.0 - initial release
// ============================================================================
module param_onehot_decoder_pipe
    import param_onehot_decoder_pkg::*;
#(
    parameter int SEL_W      = 4,
    parameter int NUM_OUT    = 10,
    parameter int ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] dec_out,
    output logic               out_last,
    output logic               out_range_err,
    output logic               err_sticky,
    input  logic               err_clr
);

    localparam logic               c_AL        = (ACTIVE_LOW != 0);
    localparam logic [NUM_OUT-1:0] c_INACTIVE  = {NUM_OUT{inactive_word(c_AL)}};
    localparam logic [NUM_OUT-1:0] c_FIRST_HOT = NUM_OUT'(1);
    localparam logic [SEL_W-1:0]   c_IDX_MAX   = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W-1:0]   c_IDX_ZERO  = '0;
    localparam logic [SEL_W-1:0]   c_IDX_ONE   = SEL_W'(1);

    state_t               r_state, w_state_nxt;
    logic [SEL_W-1:0]     r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]     r_end, w_end_nxt;
    logic                 r_scan_err, w_scan_err_nxt;
    logic                 r_out_valid, w_valid_nxt;
    logic [NUM_OUT-1:0]   r_dec, w_dec_nxt;
    logic                 r_last, w_last_nxt;
    logic                 r_rerr, w_rerr_nxt;
    logic                 r_sticky;
    logic                 w_load;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_take;
    logic [SEL_W-1:0]     w_cnt_inc;
    logic                 w_scan_last;
    logic [SEL_W-1:0]     w_core_idx;
    logic [NUM_OUT-1:0]   w_core_hot;
    logic                 w_core_rerr;
    logic [NUM_OUT-1:0]   w_core_word;
    logic [NUM_OUT-1:0]   w_first_word;
    logic [SEL_W-1:0]     w_sel_end;

    assign w_in_ready  = (r_state != SCAN) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_take      = r_out_valid && out_ready;
    assign w_cnt_inc   = r_cnt + c_IDX_ONE;
    assign w_scan_last = (w_cnt_inc == r_end);

    // No command is accepted while scanning, so the single decoder is shared:
    // it sees the next scan index in SCAN and the incoming index otherwise.
    assign w_core_idx  = (r_state == SCAN) ? w_cnt_inc : in_sel;

    // Last index of a scan, clamped to the top output.
    assign w_sel_end   = w_core_rerr ? c_IDX_MAX : in_sel;

    onehot_dec_core #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_core (
        .i_idx       (w_core_idx),
        .o_onehot    (w_core_hot),
        .o_range_err (w_core_rerr)
    );

    // Apply output polarity to the decoded word and to the scan's first beat.
    always_comb begin
        w_core_word  = '0;
        w_first_word = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            w_core_word[i]  = polarity(w_core_hot[i], c_AL);
            w_first_word[i] = polarity(c_FIRST_HOT[i], c_AL);
        end
    end

    // Next-state and next-output-register logic; every value holds by default
    // so a stalled beat never toggles.
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_valid_nxt    = r_out_valid;
        w_dec_nxt      = r_dec;
        w_last_nxt     = r_last;
        w_rerr_nxt     = r_rerr;
        w_cnt_nxt      = r_cnt;
        w_end_nxt      = r_end;
        w_scan_err_nxt = r_scan_err;
        case (r_state)
            SCAN: begin
                if (w_take) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = w_cnt_inc;
                    w_dec_nxt   = w_core_word;
                    w_last_nxt  = w_scan_last;
                    w_rerr_nxt  = w_scan_last && r_scan_err;
                    if (w_scan_last) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            default: begin
                // IDLE / HOLD: retire the held beat, then possibly load a new one.
                if (w_take) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b1;
                    if (!in_mode) begin
                        w_dec_nxt   = w_core_word;
                        w_last_nxt  = 1'b1;
                        w_rerr_nxt  = w_core_rerr;
                        w_state_nxt = HOLD;
                    end else begin
                        w_cnt_nxt      = c_IDX_ZERO;
                        w_end_nxt      = w_sel_end;
                        w_scan_err_nxt = w_core_rerr;
                        w_dec_nxt      = w_first_word;
                        w_last_nxt     = (w_sel_end == c_IDX_ZERO);
                        w_rerr_nxt     = w_core_rerr && (w_sel_end == c_IDX_ZERO);
                        w_state_nxt    = (w_sel_end == c_IDX_ZERO) ? HOLD : SCAN;
                    end
                end
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output, scan-counter and end-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_dec       <= c_INACTIVE;
            r_last      <= 1'b0;
            r_rerr      <= 1'b0;
            r_cnt       <= c_IDX_ZERO;
            r_end       <= c_IDX_ZERO;
            r_scan_err  <= 1'b0;
        end else begin
            r_out_valid <= w_valid_nxt;
            r_dec       <= w_dec_nxt;
            r_last      <= w_last_nxt;
            r_rerr      <= w_rerr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_end       <= w_end_nxt;
            r_scan_err  <= w_scan_err_nxt;
        end
    end

    // Sticky error: a range-error beat being loaded beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= (w_load && w_rerr_nxt) || (r_sticky && !err_clr);
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign dec_out       = r_dec;
    assign out_last      = r_last;
    assign out_range_err = r_rerr;
    assign err_sticky    = r_sticky;

endmodule : param_onehot_decoder_pipe
`default_nettype wire

// File: tb/tb_param_onehot_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_param_onehot_decoder_pipe
// Brief   : Self-checking bench: vector table plus scoreboard for beats.
// Revision: 1.0 - initial release
// ============================================================================
module tb_param_onehot_decoder_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sel;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] dec_out;
    logic       out_last;
    logic       out_range_err;
    logic       err_sticky;
    logic       err_clr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] sel;
        logic [9:0] exp_dec;
        logic       exp_last;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [9:0] dec;
        logic       last;
        logic       err;
    } beat_t;

    vec_t  vecs [7];
    beat_t sb_q [$];

    param_onehot_decoder_pipe #(
        .SEL_W      (4),
        .NUM_OUT    (10),
        .ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sel        (in_sel),
        .in_mode       (in_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dec_out       (dec_out),
        .out_last      (out_last),
        .out_range_err (out_range_err),
        .err_sticky    (err_sticky),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: active-low one-hot word for an index.
    function automatic logic [9:0] word_of(input int idx);
        logic [9:0] one;
        one = 10'b1;
        if (idx < 10) return ~(one << idx);
        return 10'h3FF;
    endfunction

    task automatic push_beat(input logic [9:0] d, input logic l, input logic e);
        beat_t b;
        b.dec  = d;
        b.last = l;
        b.err  = e;
        sb_q.push_back(b);
    endtask

    task automatic push_scan(input int sel);
        int e;
        e = (sel > 9) ? 9 : sel;
        for (int i = 0; i <= e; i++) begin
            push_beat(word_of(i), (i == e), (i == e) && (sel > 9));
        end
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic send(input logic [3:0] sel, input logic mode);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_mode  = mode;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got in_ready=0 for 40 cycles expected accept of sel=%0d", sel);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending_beats", sb_q.size(), 0);
    endtask

    // Scoreboard: every beat the consumer takes must match the next expectation.
    always @(negedge clk) begin
        beat_t b;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got dec_out=%h expected no beat", dec_out);
            end else begin
                b = sb_q.pop_front();
                chk("beat_dec_out", dec_out, b.dec);
                chk("beat_out_last", out_last, b.last);
                chk("beat_range_err", out_range_err, b.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        vecs[0] = '{4'd0,  10'h3FE, 1'b1, 1'b0};
        vecs[1] = '{4'd9,  10'h1FF, 1'b1, 1'b0};
        vecs[2] = '{4'd5,  10'h3DF, 1'b1, 1'b0};
        vecs[3] = '{4'd10, 10'h3FF, 1'b1, 1'b1};
        vecs[4] = '{4'd1,  10'h3FD, 1'b1, 1'b0};
        vecs[5] = '{4'd15, 10'h3FF, 1'b1, 1'b1};
        vecs[6] = '{4'd7,  10'h37F, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_mode = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;

        // Reset
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset_dec_out", dec_out, 10'h3FF);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_err_sticky", err_sticky, 1'b0);
        chk("reset_out_last", out_last, 1'b0);
        chk("reset_range_err", out_range_err, 1'b0);
        rst = 1'b0;
        #1 chk("ready_after_reset", in_ready, 1'b1);
        @(posedge clk); #1;

        // DIRECT sel=3
        push_beat(10'h3F7, 1'b1, 1'b0);
        send(4'd3, 1'b0);
        @(negedge clk);
        chk("direct3_out_valid", out_valid, 1'b1);
        @(posedge clk); #1;

        // Table of back-to-back DIRECT vectors
        for (int i = 0; i < 7; i++) begin
            push_beat(vecs[i].exp_dec, vecs[i].exp_last, vecs[i].exp_err);
            send(vecs[i].sel, 1'b0);
        end
        drain();
        chk("table_sticky_set", err_sticky, 1'b1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("table_sticky_cleared", err_sticky, 1'b0);

        // DIRECT sel=12: range error and sticky behaviour
        push_beat(10'h3FF, 1'b1, 1'b1);
        send(4'd12, 1'b0);
        chk("sel12_sticky_set", err_sticky, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("sel12_sticky_holds", err_sticky, 1'b1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("sel12_sticky_cleared", err_sticky, 1'b0);

        // Set and clear on the same cycle: set wins
        push_beat(10'h3FF, 1'b1, 1'b1);
        err_clr = 1'b1;
        send(4'd13, 1'b0);
        err_clr = 1'b0;
        chk("set_beats_clear", err_sticky, 1'b1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("sticky_cleared_again", err_sticky, 1'b0);
        drain();

        // SCAN sel=2 with out_ready pattern 1,0,1,1
        push_scan(2);
        send(4'd2, 1'b1);
        out_ready = 1'b1;
        @(negedge clk); chk("scan_b0_in_ready", in_ready, 1'b0);
        @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        chk("scan_b1_dec", dec_out, 10'h3FD);
        chk("scan_b1_in_ready", in_ready, 1'b0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        chk("scan_b1_held", dec_out, 10'h3FD);
        chk("scan_b1_last", out_last, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("scan_b2_last", out_last, 1'b1);
        chk("scan_b2_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("scan_done_valid", out_valid, 1'b0);
        chk("scan_done_dec_held", dec_out, 10'h3FB);
        @(posedge clk); #1;
        drain();

        // SCAN beyond range, and single-beat SCAN
        push_scan(12);
        send(4'd12, 1'b1);
        push_scan(0);
        send(4'd0, 1'b1);
        drain();
        chk("scan12_sticky", err_sticky, 1'b1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;

        // Backpressure: sel=5 accepted, sel=6 waits
        out_ready = 1'b0;
        push_beat(10'h3DF, 1'b1, 1'b0);
        send(4'd5, 1'b0);
        in_valid = 1'b1; in_sel = 4'd6; in_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_dec_out", dec_out, 10'h3DF);
            chk("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push_beat(10'h3BF, 1'b1, 1'b0);
        send(4'd6, 1'b0);
        drain();

        // Reset during the second beat of SCAN sel=9
        push_beat(10'h3FF, 1'b1, 1'b1);
        send(4'd14, 1'b0);
        drain();
        push_scan(9);
        send(4'd9, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("midscan_rst_valid", out_valid, 1'b0);
        chk("midscan_rst_dec", dec_out, 10'h3FF);
        chk("midscan_rst_sticky", err_sticky, 1'b0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("no_beats_after_rst", bad, 0);
        @(posedge clk); #1;
        push_beat(10'h3FE, 1'b1, 1'b0);
        send(4'd0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_param_onehot_decoder_pipe
`default_nettype wire
